// File: rtl/risc_pkg.sv
// Shared types and constants for the RISC pipeline front end.
package risc_pkg;
  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam logic [INST_W-1:0] HALT_INST = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: credit-limited imem fetch, output FIFO, redirect flush.
// Optional halt detection when INST_PREFETCH_HALT_DETECT_EN is defined.
module inst_prefetch_queue
  import risc_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  input  logic              out_ready,
  output logic              fetch_halted
);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] tracker_pc;
  logic [CW:0]     occupancy;
  logic            grant;
  logic            accept;
  logic            pop;
  logic            out_full;
  logic            out_empty;
  logic            tracker_full;
  logic            tracker_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign occupancy  = {1'b0, count} + {1'b0, inflight};
  // Gated by rst_n so the request is low for the whole reset period.
  assign imem_req   = rst_n & ~redirect_valid & ~fetch_halted & (occupancy < (CW+1)'(DEPTH));
  assign imem_addr  = fetch_pc;
  assign grant      = imem_req & imem_gnt;
  assign accept     = imem_rvalid & (drop_cnt == '0) & ~redirect_valid;
  assign out_valid  = ~out_empty & ~redirect_valid;
  assign pop        = out_valid & out_ready;
  assign push_entry = '{inst: imem_rdata, pc: tracker_pc};
  assign out_inst   = head.inst;
  assign out_pc     = head.pc;

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect_valid),
    .push  (accept),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .count (count),
    .full  (out_full),
    .empty (out_empty)
  );

  // Tracker is never cleared: stale requests still return and must pop their PC.
  sync_fifo #(.WIDTH(PC_W), .DEPTH(DEPTH)) u_pc_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .push  (grant),
    .pop   (imem_rvalid),
    .wdata (fetch_pc),
    .rdata (tracker_pc),
    .count (inflight),
    .full  (tracker_full),
    .empty (tracker_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      drop_cnt <= inflight - CW'(imem_rvalid);
    end else begin
      if (grant) fetch_pc <= fetch_pc + 1'b1;
      if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
    end
  end

`ifdef INST_PREFETCH_HALT_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     fetch_halted <= 1'b0;
    else if (redirect_valid)                        fetch_halted <= 1'b0;
    else if (accept && imem_rdata == HALT_INST)     fetch_halted <= 1'b1;
  end
`else
  assign fetch_halted = 1'b0;
`endif

  a_rvalid_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> !tracker_empty);
  a_no_tracker_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    grant |-> (!tracker_full || imem_rvalid));
  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> (!out_full || pop));
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized self-checking bench for inst_prefetch_queue with an epoch-tagged memory model.
module tb_inst_prefetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic        fetch_halted;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .fetch_halted   (fetch_halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  int          cyc, epoch, m_buf;
  int          n_grants, n_pops;
  int          n_tests, n_fail;
  int          gnt_pct = 100, lat_min = 1, lat_max = 1;
  bit          halt_word_en;
  bit          m_halted, exp_req, exp_valid, hold;
  logic [31:0] m_fetch_pc, m_next_pc, hold_pc, hold_inst;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (halt_word_en && a == 32'd5) return 32'hFFFF_FFFF;
    return a + 32'd100;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    out_ready = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    memq.delete();
    epoch++;
    m_buf = 0;
    m_fetch_pc = RESET_PC;
    m_next_pc = RESET_PC;
    m_halted = 1'b0;
    hold = 1'b0;
  endtask

  // One clock of traffic: drive inputs, check outputs against the model, advance the model.
  task automatic run_cycle(input bit redir, input logic [31:0] rpc, input bit ready);
    mreq_t r;
    bit    popped;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc = rpc;
    out_ready = ready;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = word_at(memq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
    end
    #1;
    exp_req   = !redir && !m_halted && (m_buf + memq.size() < DEPTH);
    exp_valid = (m_buf != 0) && !redir;

    n_tests++;
    if (imem_req !== exp_req) begin
      n_fail++;
      $display("FAIL imem_req cyc %0d: got %b want %b", cyc, imem_req, exp_req);
    end
    if (exp_req) begin
      n_tests++;
      if (imem_addr !== m_fetch_pc) begin
        n_fail++;
        $display("FAIL imem_addr cyc %0d: got %h want %h", cyc, imem_addr, m_fetch_pc);
      end
    end
    n_tests++;
    if (out_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL out_valid cyc %0d: got %b want %b", cyc, out_valid, exp_valid);
    end
    n_tests++;
    if (fetch_halted !== m_halted) begin
      n_fail++;
      $display("FAIL fetch_halted cyc %0d: got %b want %b", cyc, fetch_halted, m_halted);
    end
    if (exp_valid && hold) begin
      n_tests++;
      if (out_pc !== hold_pc || out_inst !== hold_inst) begin
        n_fail++;
        $display("FAIL stall_hold cyc %0d: got pc %h inst %h want pc %h inst %h",
                 cyc, out_pc, out_inst, hold_pc, hold_inst);
      end
    end
    popped = exp_valid && ready;
    if (popped) begin
      n_tests++;
      if (out_pc !== m_next_pc || out_inst !== word_at(m_next_pc)) begin
        n_fail++;
        $display("FAIL pop_data cyc %0d: got pc %h inst %h want pc %h inst %h",
                 cyc, out_pc, out_inst, m_next_pc, word_at(m_next_pc));
      end
    end
    if (out_valid && ready) n_pops++;

    if (imem_rvalid) begin
      r = memq.pop_front();
      if (!redir && r.epoch == epoch) begin
        m_buf++;
`ifdef INST_PREFETCH_HALT_DETECT_EN
        if (word_at(r.addr) == 32'hFFFF_FFFF) m_halted = 1'b1;
`endif
      end
    end
    if (popped) begin
      m_buf--;
      m_next_pc = m_next_pc + 32'd1;
    end
    hold = exp_valid && !ready;
    hold_pc = out_pc;
    hold_inst = out_inst;
    if (imem_req && imem_gnt) begin
      r.addr = imem_addr;
      r.epoch = epoch;
      r.due = cyc + int'($urandom_range(lat_max, lat_min));
      memq.push_back(r);
      m_fetch_pc = m_fetch_pc + 32'd1;
      n_grants++;
    end
    if (redir) begin
      epoch++;
      m_buf = 0;
      m_fetch_pc = rpc;
      m_next_pc = rpc;
      m_halted = 1'b0;
      hold = 1'b0;
    end
    cyc++;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || fetch_halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req %b valid %b halted %b want 0 0 0", imem_req, out_valid, fetch_halted);
    end
    n_tests++;
    if (out_inst !== 32'h0 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got inst %h pc %h want 0 0", out_inst, out_pc);
    end
    release_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    run_cycle(1'b0, '0, 1'b1);
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: got req %b addr %h want 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_zero_wait();
    int g0;
    apply_reset();
    release_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    g0 = n_grants;
    run_cycle(1'b0, '0, 1'b1);
    run_cycle(1'b0, '0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_cycle1: got valid %b want 0", out_valid);
    end
    run_cycle(1'b0, '0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_inst !== 32'd100) begin
      n_fail++;
      $display("FAIL fill_cycle2: got valid %b pc %h inst %h want 1 0 64", out_valid, out_pc, out_inst);
    end
    repeat (27) run_cycle(1'b0, '0, 1'b1);
    n_tests++;
    if (n_grants - g0 != 30) begin
      n_fail++;
      $display("FAIL zero_wait_rate: got %0d grants want 30", n_grants - g0);
    end
  endtask

  task automatic test_stall();
    int g0, p0;
    apply_reset();
    release_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    g0 = n_grants;
    repeat (10) run_cycle(1'b0, '0, 1'b0);
    n_tests++;
    if (n_grants - g0 != DEPTH || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_credit: got %0d grants req %b want %0d 0", n_grants - g0, imem_req, DEPTH);
    end
    n_tests++;
    if (out_pc !== 32'd0 || out_inst !== 32'd100) begin
      n_fail++;
      $display("FAIL stall_head: got pc %h inst %h want 0 64", out_pc, out_inst);
    end
    p0 = n_pops;
    repeat (8) run_cycle(1'b0, '0, 1'b1);
    n_tests++;
    if (n_pops - p0 < DEPTH) begin
      n_fail++;
      $display("FAIL stall_drain: got %0d pops want >= %0d", n_pops - p0, DEPTH);
    end
  endtask

  task automatic test_redirect_stale();
    logic [31:0] first_pc;
    bit          seen;
    int          stale;
    apply_reset();
    release_reset();
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    run_cycle(1'b0, '0, 1'b1);
    run_cycle(1'b0, '0, 1'b1);
    run_cycle(1'b1, 32'h40, 1'b1);
    seen = 1'b0; stale = 0; first_pc = '0;
    repeat (14) begin
      run_cycle(1'b0, '0, 1'b1);
      if (out_valid && out_pc < 32'h40) stale++;
      if (out_valid && !seen) begin
        seen = 1'b1;
        first_pc = out_pc;
      end
    end
    n_tests++;
    if (!seen || first_pc !== 32'h40 || stale != 0) begin
      n_fail++;
      $display("FAIL redirect_stale: got seen %b first pc %h stale %0d want 1 40 0", seen, first_pc, stale);
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    logic [31:0] first_pc;
    bit          seen;
    apply_reset();
    release_reset();
    gnt_pct = 100; lat_min = 2; lat_max = 2;
    repeat (6) run_cycle(1'b0, '0, 1'b1);
    run_cycle(1'b1, 32'h80, 1'b1);
    run_cycle(1'b0, '0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_flush: got valid %b want 0", out_valid);
    end
    seen = 1'b0; first_pc = '0;
    repeat (10) begin
      run_cycle(1'b0, '0, 1'b1);
      if (out_valid && !seen) begin
        seen = 1'b1;
        first_pc = out_pc;
      end
    end
    n_tests++;
    if (!seen || first_pc !== 32'h80) begin
      n_fail++;
      $display("FAIL redirect_restart: got seen %b pc %h want 1 80", seen, first_pc);
    end
  endtask

  task automatic test_random();
    int p0;
    bit rd;
    logic [31:0] rpc;
    apply_reset();
    release_reset();
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    p0 = n_pops;
    repeat (400) begin
      rd = ($urandom_range(99) < 4);
      rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFFD : $urandom;
      run_cycle(rd, rpc, $urandom_range(99) < 60);
    end
    n_tests++;
    if (n_pops - p0 < 40) begin
      n_fail++;
      $display("FAIL random_progress: got %0d pops want >= 40", n_pops - p0);
    end
  endtask

  task automatic test_halt();
    int g0;
    apply_reset();
    release_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    halt_word_en = 1'b1;
    repeat (20) run_cycle(1'b0, '0, 1'b1);
`ifdef INST_PREFETCH_HALT_DETECT_EN
    n_tests++;
    if (fetch_halted !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_set: got halted %b req %b want 1 0", fetch_halted, imem_req);
    end
    g0 = n_grants;
    repeat (5) run_cycle(1'b0, '0, 1'b1);
    n_tests++;
    if (n_grants != g0) begin
      n_fail++;
      $display("FAIL halt_no_req: got %0d grants want 0", n_grants - g0);
    end
    halt_word_en = 1'b0;
    run_cycle(1'b1, 32'h0, 1'b1);
    run_cycle(1'b0, '0, 1'b1);
    n_tests++;
    if (fetch_halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL halt_clear: got halted %b req %b addr %h want 0 1 0", fetch_halted, imem_req, imem_addr);
    end
`else
    g0 = n_grants;
    n_tests++;
    if (fetch_halted !== 1'b0 || g0 < 20) begin
      n_fail++;
      $display("FAIL halt_disabled: got halted %b grants %0d want 0 >=20", fetch_halted, g0);
    end
    halt_word_en = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    release_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (10) run_cycle(1'b0, '0, 1'b0);
    apply_reset();
    n_tests++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid %b req %b pc %h inst %h want 0 0 0 0", out_valid, imem_req, out_pc, out_inst);
    end
    release_reset();
    run_cycle(1'b0, '0, 1'b1);
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got req %b addr %h want 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_stale();
    test_redirect_rvalid_pop();
    test_halt();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the decode stage of the 4-stage RISC pipeline.
- Issues word-addressed requests to instruction memory over a req/gnt/rvalid handshake and buffers returned words with their PC in a small FIFO.
- Presents one instruction per cycle to decode under valid/ready.
- Handles redirects (taken branch or jump from EX) by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries and maximum in-flight requests; power of two, minimum 2.
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch word address
- imem_req  out  1  fetch request
- imem_addr  out  32  word address of request
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response word valid; responses arrive in order, at least 1 cycle after grant
- imem_rdata  in  32  instruction word
- out_valid  out  1  instruction available to decode
- out_inst  out  32  FIFO head instruction
- out_pc  out  32  PC of out_inst
- out_ready  in  1  decode accepts head (low = stall)
- fetch_halted  out  1  see Optional Feature

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Reset values: fetch_pc = RESET_PC; count, inflight and drop_cnt = 0; FIFO pointers = 0; imem_req, out_valid and fetch_halted = 0; out_inst and out_pc = 0.
- First imem_req is asserted in the first cycle after rst_n deasserts, with imem_addr = RESET_PC.
- count, inflight and drop_cnt are each $clog2(DEPTH+1) bits.
- Request rule: imem_req = ~redirect_valid & ~fetch_halted & (count + inflight < DEPTH). imem_addr = fetch_pc.
  - imem_req & imem_gnt: fetch_pc <= fetch_pc + 1 (wraps modulo 2^32); inflight increments.
  - imem_req held high without gnt: imem_addr stays stable.
- Response rule: imem_rvalid decrements inflight.
  - drop_cnt > 0: word is discarded and drop_cnt decrements.
  - Otherwise: {imem_rdata, pc} is pushed into the FIFO. pc comes from a parallel in-flight PC tracker holding DEPTH entries.
- Credit scheme guarantees a push never overflows the FIFO. An rvalid with inflight == 0 is a protocol error; `assert` it in simulation.
- Latency: an rvalid at cycle t gives out_valid at t+1 when the FIFO was empty. No bypass path.
- Output: out_valid = (count != 0) & ~redirect_valid. Pop occurs on out_valid & out_ready. Push and pop in the same cycle leave count unchanged.
- FIFO full with out_ready low: no new requests are issued and the held head is stable.
- Redirect (highest priority), at cycle t:
  - FIFO is cleared at the edge; any pop or push in cycle t is ignored.
  - drop_cnt <= inflight − (imem_rvalid ? 1 : 0).
  - fetch_pc <= redirect_pc.
  - New imem_req at t+1.
- Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
- Reset mid-operation clears all state immediately. Responses arriving after reset are treated as new data; the memory is reset by the same rst_n.

Optional Feature:
- Macro: INST_PREFETCH_HALT_DETECT_EN.
- Defined:
  - A pushed word equal to 32'hFFFFFFFF sets fetch_halted at the next edge.
  - While fetch_halted is set, no new requests are issued. Already in-flight responses are still accepted, and the FIFO keeps draining to decode.
  - fetch_halted clears on redirect_valid or reset.
- Undefined: fetch_halted is tied to 0 and 32'hFFFFFFFF is treated as an ordinary word.

Decomposition:
- Shared package risc_pkg holds:
  - INST_W = 32, PC_W = 32, HALT_INST = 32'hFFFFFFFF
  - typedef fetch_entry_t {inst, pc}
- One sub-module, sync_fifo: parameterised width and depth, with push, pop, clear, count, full and empty.
  - Instantiated twice: once as the output FIFO and once as the in-flight PC tracker.

Test Plan:
- Zero-wait memory (gnt = 1, rvalid 1 cycle later, rdata = addr + 100), out_ready = 1 -> out_pc 0,1,2,3… with out_inst 100,101,102…; one instruction per cycle after a 2-cycle fill.
- out_ready = 0 for 10 cycles -> exactly DEPTH = 4 requests issued, imem_req drops, out_inst/out_pc stable; releasing out_ready drains 0..3 in order with no loss.
- Memory latency 3 with 2 responses in flight, redirect_pc = 0x40 -> both stale words discarded; next out_pc = 0x40 and out_valid is never high for stale data.
- Redirect coinciding with rvalid and a pop in the same cycle -> that word is dropped, drop_cnt = inflight − 1, and the FIFO is empty at the next cycle.
- INST_PREFETCH_HALT_DETECT_EN defined, word 0xFFFFFFFF at pc 5 -> fetch_halted = 1 one cycle after the push, no further imem_req; redirect to 0 clears it and restarts fetch.
- Assert rst_n low mid-stream with a full FIFO -> out_valid and imem_req go low immediately; after release, the first imem_addr = RESET_PC.
